// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream packet arbiter: tdest width, arbiter
// state encoding and the round-robin selection helper.
package axis_pkg;

  localparam int TDEST_WIDTH = 32;
  localparam int MAX_SRC     = 8;
  localparam int PTR_WIDTH   = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // First asserted request scanning upward from ptr with wrap. Callers with
  // fewer than MAX_SRC sources zero-pad req, which gives the same result as
  // wrapping at their own source count.
  function automatic logic [PTR_WIDTH-1:0] rr_pick(
    input logic [MAX_SRC-1:0]   req,
    input logic [PTR_WIDTH-1:0] ptr
  );
    logic [PTR_WIDTH-1:0] idx;
    logic                 found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < MAX_SRC; k++) begin
      idx = ptr + PTR_WIDTH'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer: fully registered data path, and an input ready that
// comes straight from a flop so it never depends on out_ready.
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic             skid_valid_reg;
  logic [WIDTH-1:0] skid_data_reg;
  logic             in_fire;
  logic             out_open;

  assign in_fire  = in_valid && !skid_valid_reg;
  assign out_open = !out_valid_reg || out_ready;

  // The skid entry only fills when the output register is stalled, so
  // "skid empty" is exactly the condition for accepting another beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
    end else begin
      if (out_open) begin
        if (skid_valid_reg) begin
          out_valid_reg  <= 1'b1;
          out_data_reg   <= skid_data_reg;
          skid_valid_reg <= 1'b0;
        end else if (in_fire) begin
          out_valid_reg <= 1'b1;
          out_data_reg  <= in_data;
        end else begin
          out_valid_reg <= 1'b0;
        end
      end else if (in_fire) begin
        skid_valid_reg <= 1'b1;
        skid_data_reg  <= in_data;
      end
    end
  end

  assign in_ready  = !skid_valid_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin merge of NUM_SRC AXI-Stream sources; each output
// beat is tagged on m_tdest with the index of the source that supplied it.
module axis_packet_arbiter
  import axis_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC-1:0]            s_tvalid,
  output logic [NUM_SRC-1:0]            s_tready,
  input  logic [NUM_SRC-1:0]            s_tlast,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic [TDEST_WIDTH-1:0]        m_tdest,
  output logic                          busy,
  output logic [IDX_WIDTH-1:0]          grant_idx
);

  localparam int SKID_WIDTH = DATA_WIDTH + 1 + IDX_WIDTH;

  arb_state_t           state_reg;
  logic [IDX_WIDTH-1:0] grant_idx_reg;
  logic [PTR_WIDTH-1:0] rr_ptr_reg;
  logic                 busy_reg;

  logic [NUM_SRC-1:0]    grant_sel;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  skid_in_valid;
  logic                  skid_in_ready;
  logic [SKID_WIDTH-1:0] skid_in_data;
  logic                  skid_out_valid;
  logic [SKID_WIDTH-1:0] skid_out_data;
  logic                  beat_fire;
  logic                  pkt_done;
  logic [PTR_WIDTH-1:0]  pick_idx;
  logic [PTR_WIDTH-1:0]  grant_ptr;
  logic [PTR_WIDTH-1:0]  ptr_after;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_sel
      assign grant_sel[gi] = (grant_idx_reg == IDX_WIDTH'(gi));
    end
  endgenerate

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_sel[i]) begin
        sel_data = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign sel_valid     = |(s_tvalid & grant_sel);
  assign sel_last      = |(s_tlast & grant_sel);
  assign skid_in_valid = (state_reg == LOCKED) && sel_valid;
  assign skid_in_data  = {sel_data, sel_last, grant_idx_reg};
  assign beat_fire     = skid_in_valid && skid_in_ready;
  assign pkt_done      = beat_fire && sel_last;

  // Only the granted source ever sees ready, and only while locked.
  assign s_tready = (state_reg == LOCKED) ? (grant_sel & {NUM_SRC{skid_in_ready}})
                                          : '0;

  assign pick_idx  = rr_pick(MAX_SRC'(s_tvalid), rr_ptr_reg);
  assign grant_ptr = PTR_WIDTH'(grant_idx_reg);
  assign ptr_after = (grant_ptr == PTR_WIDTH'(NUM_SRC - 1)) ? '0
                                                            : grant_ptr + PTR_WIDTH'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      grant_idx_reg <= '0;
      rr_ptr_reg    <= '0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|s_tvalid) begin
            grant_idx_reg <= IDX_WIDTH'(pick_idx);
            state_reg     <= LOCKED;
            busy_reg      <= 1'b1;
          end
        end
        LOCKED: begin
          // Grant is released only by a tlast transfer; a source that drops
          // tvalid mid-packet keeps the arbiter waiting here.
          if (pkt_done) begin
            rr_ptr_reg <= ptr_after;
            state_reg  <= IDLE;
            busy_reg   <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  axis_skid_buffer #(
    .WIDTH(SKID_WIDTH)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_valid (skid_in_valid),
    .in_ready (skid_in_ready),
    .in_data  (skid_in_data),
    .out_valid(skid_out_valid),
    .out_ready(m_tready),
    .out_data (skid_out_data)
  );

  assign m_tvalid  = skid_out_valid;
  assign m_tdata   = skid_out_data[SKID_WIDTH-1 -: DATA_WIDTH];
  assign m_tlast   = skid_out_data[IDX_WIDTH];
  assign m_tdest   = TDEST_WIDTH'(skid_out_data[IDX_WIDTH-1:0]);
  assign busy      = busy_reg;
  assign grant_idx = grant_idx_reg;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Scoreboard bench for axis_packet_arbiter with three sources: per-source
// expected beats are queued on source transfer and popped on output transfer.
module tb_axis_packet_arbiter;

  localparam int NS = 3;
  localparam int DW = 32;
  localparam int IW = 3;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NS-1:0]    s_tvalid;
  logic [NS-1:0]    s_tready;
  logic [NS-1:0]    s_tlast;
  logic [NS*DW-1:0] s_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic             m_tlast;
  logic [DW-1:0]    m_tdata;
  logic [31:0]      m_tdest;
  logic             busy;
  logic [IW-1:0]    grant_idx;

  always #5 clk = ~clk;

  axis_packet_arbiter #(
    .NUM_SRC(NS),
    .DATA_WIDTH(DW),
    .IDX_WIDTH(IW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .s_tlast(s_tlast),
    .s_tdata(s_tdata),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tlast(m_tlast),
    .m_tdata(m_tdata),
    .m_tdest(m_tdest),
    .busy(busy),
    .grant_idx(grant_idx)
  );

  int total = 0;
  int bad = 0;

  beat_t       src_q[NS][$];
  beat_t       exp_q[NS][$];
  int          sent_cnt[NS];
  int          stall_at[NS];
  int          stall_left[NS];
  logic        stalled[NS];
  logic        tv[NS];
  logic        tl[NS];
  logic [31:0] td[NS];
  logic        pres[NS];
  logic        rand_ready = 1'b0;
  logic        rand_gaps = 1'b0;
  logic        ready_level = 1'b1;

  int m_state = 0;
  int m_ptr = 0;
  int m_grant = 0;

  int          pkt_dest[$];
  int          pkt_len[$];
  int          gap_log[$];
  int          cur_len = 0;
  int          cyc = 0;
  int          last_end = -1;
  int          in_beats = 0;
  int          out_beats = 0;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_data;
  logic [31:0] hold_dest;
  logic        hold_last;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic all_empty();
    logic e = 1'b1;
    for (int s = 0; s < NS; s++) begin
      if (src_q[s].size() != 0 || exp_q[s].size() != 0) e = 1'b0;
    end
    return e;
  endfunction

  task automatic push_pkt(int s, int len, logic [31:0] base);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = base + 32'(i);
      b.last = (i == len - 1);
      src_q[s].push_back(b);
    end
  endtask

  task automatic clear_logs();
    pkt_dest.delete();
    pkt_len.delete();
    gap_log.delete();
    last_end  = -1;
    in_beats  = 0;
    out_beats = 0;
    for (int s = 0; s < NS; s++) begin
      sent_cnt[s]   = 0;
      stall_at[s]   = -1;
      stall_left[s] = 0;
    end
  endtask

  // One clock: check the model state, drive sources, resolve handshakes.
  task automatic step();
    logic [NS-1:0] xfer;
    logic          any_req;
    beat_t         b;
    int            src;
    @(negedge clk);
    check("busy", busy, (m_state == 1));
    check("grant_idx", grant_idx, m_grant);
    any_req = 1'b0;
    for (int s = 0; s < NS; s++) begin
      tv[s] = 1'b0;
      tl[s] = 1'b0;
      td[s] = '0;
      stalled[s] = 1'b0;
      if (src_q[s].size() > 0) begin
        if (stall_left[s] > 0 && sent_cnt[s] == stall_at[s]) begin
          stall_left[s]--;
          stalled[s] = 1'b1;
        end else if (rand_gaps && !pres[s] && $urandom_range(0, 3) == 0) begin
          stalled[s] = 1'b1;
        end else begin
          tv[s] = 1'b1;
          td[s] = src_q[s][0].data;
          tl[s] = src_q[s][0].last;
        end
      end
      s_tvalid[s]          = tv[s];
      s_tlast[s]           = tl[s];
      s_tdata[s*DW +: DW]  = td[s];
      any_req              = any_req | tv[s];
    end
    m_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
    #1;
    for (int s = 0; s < NS; s++) begin
      xfer[s] = tv[s] && s_tready[s];
      pres[s] = tv[s] && !s_tready[s];
      if (xfer[s]) begin
        exp_q[s].push_back(src_q[s].pop_front());
        sent_cnt[s]++;
        in_beats++;
      end
    end
    if (m_state == 0) begin
      if (any_req) begin
        for (int k = 0; k < NS; k++) begin
          int idx = (m_ptr + k) % NS;
          if (tv[idx]) begin
            m_grant = idx;
            break;
          end
        end
        m_state = 1;
      end
    end else if (xfer[m_grant] && tl[m_grant]) begin
      m_ptr   = (m_grant + 1) % NS;
      m_state = 0;
    end
    if (hold_pend) begin
      check("hold_valid", m_tvalid, 1);
      check("hold_data", m_tdata, hold_data);
      check("hold_dest", m_tdest, hold_dest);
      check("hold_last", m_tlast, hold_last);
    end
    hold_pend = m_tvalid && !m_tready;
    hold_data = m_tdata;
    hold_dest = m_tdest;
    hold_last = m_tlast;
    if (m_tvalid && m_tready) begin
      out_beats++;
      if (cur_len == 0 && last_end >= 0) gap_log.push_back(cyc - last_end - 1);
      cur_len++;
      check("tdest_range", (m_tdest < NS), 1);
      if (m_tdest < NS) begin
        src = int'(m_tdest);
        check("beat_pending", (exp_q[src].size() > 0), 1);
        if (exp_q[src].size() > 0) begin
          b = exp_q[src].pop_front();
          check("data", m_tdata, b.data);
          check("last", m_tlast, b.last);
        end
      end
      if (m_tlast) begin
        $display("pkt src=%0d len=%0d cycle=%0d", m_tdest, cur_len, cyc);
        pkt_dest.push_back(int'(m_tdest));
        pkt_len.push_back(cur_len);
        cur_len  = 0;
        last_end = cyc;
      end
    end
    cyc++;
  endtask

  task automatic drain(int budget);
    int   n = 0;
    logic done = 1'b0;
    while (!done && n < budget) begin
      step();
      n++;
      done = all_empty() && !m_tvalid;
    end
    check("drain", done, 1);
  endtask

  task automatic wait_sent(int s, int target, int budget);
    int n = 0;
    while (sent_cnt[s] < target && n < budget) begin
      step();
      n++;
    end
    check("wait_sent", (sent_cnt[s] >= target), 1);
  endtask

  task automatic check_order(string tag, int d0, int l0, int d1, int l1);
    check({tag, "_npkt"}, pkt_dest.size(), 2);
    if (pkt_dest.size() >= 2) begin
      check({tag, "_dest0"}, pkt_dest[0], d0);
      check({tag, "_len0"}, pkt_len[0], l0);
      check({tag, "_dest1"}, pkt_dest[1], d1);
      check({tag, "_len1"}, pkt_len[1], l1);
    end
  endtask

  initial begin
    int nstall;
    int n;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    m_tready = 1'b0;
    for (int s = 0; s < NS; s++) begin
      pres[s] = 1'b0;
      stalled[s] = 1'b0;
    end
    clear_logs();
    repeat (3) @(negedge clk);

    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tdest", m_tdest, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_idx, 0);
    reset = 1'b0;

    // Idle with no requests
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_mvalid", m_tvalid, 0);
      check("idle_tready", s_tready, 0);
    end

    // Fairness with 4-beat packets on sources 0 and 1
    clear_logs();
    for (int p = 0; p < 3; p++) begin
      push_pkt(0, 4, 32'h100);
      push_pkt(1, 4, 32'h200);
    end
    drain(300);
    check("fair_npkt", pkt_dest.size(), 6);
    for (int i = 0; i < pkt_dest.size(); i++) begin
      check("fair_dest", pkt_dest[i], i % 2);
      check("fair_len", pkt_len[i], 4);
    end
    check("fair_ngap", gap_log.size(), 5);
    foreach (gap_log[i]) check("fair_gap", gap_log[i], 1);

    // Source 0 requests in the middle of a source 1 packet
    clear_logs();
    push_pkt(1, 6, 32'h300);
    wait_sent(1, 2, 50);
    push_pkt(0, 3, 32'h400);
    n = 0;
    while (src_q[1].size() > 0 && n < 100) begin
      step();
      check("pre_tready0", s_tready[0], 0);
      n++;
    end
    drain(100);
    check_order("pre", 1, 6, 0, 3);

    // Source 0 drops tvalid for 5 cycles mid-packet
    clear_logs();
    push_pkt(0, 8, 32'h500);
    stall_at[0]   = 3;
    stall_left[0] = 5;
    wait_sent(0, 1, 20);
    push_pkt(1, 4, 32'h600);
    nstall = 0;
    n = 0;
    while (src_q[0].size() > 0 && n < 100) begin
      step();
      if (stalled[0]) begin
        check("drop_busy", busy, 1);
        check("drop_grant", grant_idx, 0);
        check("drop_tready1", s_tready[1], 0);
        nstall++;
      end
      n++;
    end
    check("drop_nstall", nstall, 5);
    drain(100);
    check_order("drop", 0, 8, 1, 4);

    // Reset during the 3rd beat with the output stalled
    clear_logs();
    ready_level = 1'b0;
    push_pkt(0, 6, 32'h700);
    wait_sent(0, 2, 50);
    step();
    check("rst_pre_mvalid", m_tvalid, 1);
    reset = 1'b1;
    #1;
    check("rst_mid_mvalid", m_tvalid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_grant", grant_idx, 0);
    check("rst_mid_tready", s_tready, 0);
    check("rst_mid_tdata", m_tdata, 0);
    for (int s = 0; s < NS; s++) begin
      src_q[s].delete();
      exp_q[s].delete();
      pres[s] = 1'b0;
    end
    s_tvalid  = '0;
    s_tlast   = '0;
    s_tdata   = '0;
    m_state   = 0;
    m_ptr     = 0;
    m_grant   = 0;
    hold_pend = 1'b0;
    cur_len   = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_logs();
    ready_level = 1'b1;
    push_pkt(1, 2, 32'h800);
    push_pkt(2, 2, 32'h900);
    drain(100);
    check_order("post_rst", 1, 2, 2, 2);

    // Random lengths, random source gaps, 50% output ready
    clear_logs();
    rand_ready = 1'b1;
    rand_gaps  = 1'b1;
    for (int s = 0; s < NS; s++) begin
      for (int p = 0; p < 5; p++) begin
        push_pkt(s, $urandom_range(1, 16), 32'(s * 32'h0100_0000 + p * 32'h0001_0000));
      end
    end
    drain(5000);
    check("rand_beats", out_beats, in_beats);
    check("rand_npkt", pkt_dest.size(), 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_packet_arbiter.md
Name: axis_packet_arbiter

Overview:
- Merges NUM_SRC AXI-Stream sources onto one master stream. Arbitration is round-robin at packet granularity: a grant is held from the first beat of a packet until its tlast beat.
- Each output beat carries m_tdest equal to the index of the source that supplied it. This lets a downstream TDEST router or DMA demux steer each packet back to its origin.
- Sits between the ADC/capture stream sources and the shared DMA-facing stream path.

Parameters:
- NUM_SRC, 2, number of slave streams; legal range 1..8.
- DATA_WIDTH, 32, tdata width per stream.
- IDX_WIDTH, 3, width of the grant index; must satisfy 2**IDX_WIDTH >= NUM_SRC.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- s_tvalid  in  NUM_SRC  per-source valid.
- s_tready  out  NUM_SRC  per-source ready.
- s_tlast  in  NUM_SRC  per-source end of packet.
- s_tdata  in  NUM_SRC*DATA_WIDTH  source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- m_tvalid  out  1  output valid.
- m_tready  in  1  output ready.
- m_tlast  out  1  output end of packet.
- m_tdata  out  DATA_WIDTH  output data.
- m_tdest  out  32  source index, zero-extended to 32 bits.
- busy  out  1  high while in LOCKED.
- grant_idx  out  IDX_WIDTH  currently or last granted source.

Behaviour:
- Reset (asynchronous, takes effect immediately): m_tvalid=0, m_tlast=0, m_tdata=0, m_tdest=0, s_tready=0, busy=0, grant_idx=0, rr_ptr=0, state=IDLE, skid buffer emptied.
- FSM states are IDLE and LOCKED.
- IDLE:
  - All s_tready are 0.
  - If any s_tvalid is high, select the first asserted source scanning upward from rr_ptr with wrap (i = rr_ptr, rr_ptr+1, ..., NUM_SRC-1, 0, ...).
  - Register the winner into grant_idx and go to LOCKED on the next edge.
  - Arbitration cost is one cycle; there is exactly one idle cycle between consecutive packets.
- LOCKED:
  - s_tready[grant_idx] equals the skid buffer's input ready; all other s_tready are 0.
  - A source beat transfers when s_tvalid[g] and s_tready[g] are both high.
  - On the transfer of a beat with s_tlast=1: go to IDLE and set rr_ptr = (g+1) mod NUM_SRC.
- Grant lock: source tvalid dropping mid-packet does not release the grant. The arbiter waits in LOCKED indefinitely; no timeout.
- Output stage is a 2-entry skid buffer:
  - Carries {tdata, tlast, tdest} through a fully registered path.
  - Latency is 1 cycle from source transfer to m_tvalid.
  - Sustains 1 beat/clock under continuous m_tready.
  - Input ready is registered and is never combinationally dependent on m_tready.
- Output rules:
  - m_tdest is captured per beat from grant_idx and is stable while m_tvalid=1 and m_tready=0.
  - No beat is dropped or duplicated under any m_tready pattern.
- Fairness: with all sources continuously requesting, grants cycle 0,1,...,NUM_SRC-1,0,...
- Boundary cases:
  - NUM_SRC=1: always grants source 0 and rr_ptr stays 0.
  - Single-beat packets are valid; one packet completes per 2 cycles plus output backpressure.
  - A new request arriving in the same cycle as a tlast transfer is only considered in the following IDLE cycle.
  - Reset mid-packet discards buffered beats. Downstream sees m_tvalid fall with no tlast; this is accepted system behaviour.

Decomposition:
- Shared package axis_pkg holds:
  - TDEST_WIDTH=32.
  - The arbiter state enum {IDLE, LOCKED}.
  - A helper function for round-robin next-index selection, rr_pick(req, ptr).
- Natural sub-module: axis_skid_buffer, parameterized by WIDTH. Reused here with WIDTH = DATA_WIDTH+1+IDX_WIDTH; the index is zero-extended to 32 bits at the output.

Test Plan:
- Reset then idle, NUM_SRC=2, no requests -> after reset all outputs are 0 and busy stays 0 for 20 cycles.
- Both sources continuously valid with 4-beat packets (source 0 data 0x100..0x103, source 1 data 0x200..0x203), m_tready=1 ->
  - output sequence 0x100..0x103 with tdest 0, then 0x200..0x203 with tdest 1, then repeats;
  - m_tlast on every 4th beat;
  - exactly one idle cycle between packets.
- Source 1 requests alone, then source 0 requests mid-packet of source 1 -> source 0 is not granted until after source 1's tlast beat, then is granted; s_tready[0] stays 0 throughout.
- Random m_tready (50%) with 3 sources and random packet lengths 1..16 -> scoreboard confirms per-source packet order and data intact, and every beat's tdest matches its source.
- Source 0 drops tvalid for 5 cycles mid-packet -> busy stays 1, grant_idx stays 0, no other source is served, packet resumes intact.
- Reset asserted during the 3rd beat of a packet with m_tready=0 -> m_tvalid=0 in the same cycle; after release, rr_ptr=0 and the next grant goes to the lowest-index requester.
